velocidad_param: RTL
====================

VELOCIDAD_PARAM -- requirements
Module: velocidad_param

Interface
REQ-001 Parameters (name, default, meaning): DW, 16, displacement width (unsigned metres, wrapping odometer).
REQ-002 Parameter CW, 32, elapsed-cycle counter width.
REQ-003 Parameter CLK_HZ, 50_000_000, clock frequency in Hz, used for the scale constant K = CLK_HZ*36.
REQ-004 Parameter TIMEOUT, 50_000_000, maximum measurement window in cycles; TIMEOUT SHALL be in 1..2^CW-1.
REQ-005 Parameter VW, 24, speed output width.
REQ-006 Port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-008 Port desplazamiento, input, DW bits: odometer value.
REQ-009 Port velocidad, output, VW bits: last speed, in units of 0.1 km/h, held between updates.
REQ-010 Port velocidad_valid, output, 1 bit: one-cycle pulse when velocidad updates.
REQ-011 Port impulso, output, 1 bit: one-cycle pulse on every measurement event.
REQ-012 Port ocupado, output, 1 bit: high while the FSM is not IDLE.
REQ-013 Port detenido, output, 1 bit: high when the last completed result came from a timeout with zero delta.
REQ-014 Port overrun, output, 1 bit: sticky flag set when a pending measurement is overwritten.

Function
REQ-015 Counter cnt (CW bits) SHALL increment each cycle and clear to 0 on every event.
REQ-016 Event: desplazamiento != prev (change event), or cnt == TIMEOUT-1 with no change (timeout event); a change takes priority when both occur in the same cycle.
REQ-017 On event: delta = (desplazamiento - prev) mod 2^DW; elapsed = cnt+1; prev <= desplazamiento; impulso = 1 for that cycle.
REQ-018 The first cycle after reset deasserts SHALL load prev from desplazamiento without generating an event (priming).
REQ-019 Result = floor(delta*K / elapsed), computed at full width NW = DW + clog2(K+1); if result > 2^VW-1, velocidad SHALL be 2^VW-1 (saturation).
REQ-020 FSM states: IDLE, MUL, DIV, DONE.
REQ-021 IDLE -> MUL when a measurement is available (new event or pending slot full).
REQ-022 MUL: compute the numerator, 1 cycle.
REQ-023 DIV: restoring division, 1 quotient bit per cycle, exactly NW cycles.
REQ-024 DONE: update velocidad and detenido, pulse velocidad_valid; 1 cycle, then go to MUL if the pending slot is full, else IDLE.
REQ-025 Latency: velocidad_valid SHALL assert exactly NW+2 cycles after the cycle following the event that started the computation.
REQ-026 Events arriving while ocupado SHALL be stored in a one-deep pending slot (delta, elapsed, timeout flag).
REQ-027 An event arriving while the pending slot is full SHALL overwrite the slot and set overrun.
REQ-028 If an event arrives in the DONE cycle, it is stored in the pending slot; it is never dropped.
REQ-029 Event counting and the cnt clear SHALL be independent of the FSM; measurement windows never stall.
REQ-030 A timeout event with delta=0 SHALL yield velocidad=0 and detenido=1; any result with delta != 0 SHALL clear detenido.
REQ-031 Division by zero cannot occur (elapsed >= 1).

Reset
REQ-032 While reset is high on a rising edge, all of the following SHALL clear to 0: velocidad, velocidad_valid, impulso, ocupado, detenido, overrun, cnt, pending slot, and priming; FSM SHALL go to IDLE.
REQ-033 Reset asserted mid-DIV SHALL abort the division; no velocidad_valid pulse SHALL follow.

Verification (bench: DW=16, CW=32, CLK_HZ=1000, K=36000, TIMEOUT=1000, VW=24)
REQ-034 Basic: hold desplazamiento=0, change to 5 when cnt=499 -> impulso pulse; velocidad=360 (36.0 km/h) with velocidad_valid NW+2 cycles later; detenido=0.
REQ-035 Timeout: hold the value constant for 1000 cycles -> impulso at cnt=999; velocidad=0; detenido=1.
REQ-036 Wrap: prev=65534, new=2 at cnt=999 -> delta=4; velocidad=144.
REQ-037 Saturation: delta=65535 at elapsed=1 -> velocidad=16777215.
REQ-038 Overrun: three changes on consecutive cycles while ocupado -> first and third results reported, second lost; overrun=1 until reset.
REQ-039 Reset mid-DIV: assert reset for 1 cycle during DIV -> all outputs 0, no velocidad_valid; next event after priming is computed correctly.

Source files
------------

// File: rtl/velocidad_param.sv
// velocidad_param: speed meter driven by a wrapping odometer.
// Each change of desplazamiento, or a full TIMEOUT window without change,
// closes a measurement window. The speed (0.1 km/h units) is computed as
// delta*K/elapsed with K = CLK_HZ*36, using a 1-cycle multiply followed by
// an NW-cycle restoring divider. One measurement can wait in a pending slot
// while the divider is busy; later arrivals overwrite it and set overrun.
//
// state | meaning
// IDLE  | divider free, waiting for a measurement in the pending slot
// MUL   | numerator delta*K formed
// DIV   | restoring division, one quotient bit per cycle, NW cycles
// DONE  | result published, next measurement picked up if one is waiting
module velocidad_param #(
  parameter int DW      = 16,
  parameter int CW      = 32,
  parameter int CLK_HZ  = 50_000_000,
  parameter int TIMEOUT = 50_000_000,
  parameter int VW      = 24
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] desplazamiento,
  output logic [VW-1:0] velocidad,
  output logic          velocidad_valid,
  output logic          impulso,
  output logic          ocupado,
  output logic          detenido,
  output logic          overrun
);

  localparam longint K  = longint'(CLK_HZ) * 36;
  localparam int     NW = DW + $clog2(K + 1);
  localparam int     QW = (NW > VW) ? NW : VW;
  localparam int     BW = $clog2(NW + 1);
  localparam logic [NW-1:0] K_N      = NW'(K);
  localparam logic [QW-1:0] V_MAX    = QW'({VW{1'b1}});
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

  logic          primed;
  logic [DW-1:0] prev;
  logic [CW-1:0] cnt;
  logic          changeEv;
  logic          timeoutEv;
  logic          eventNow;
  logic [DW-1:0] deltaNow;
  logic [CW-1:0] elapsedNow;

  stateT         state;
  logic          slotFull;
  logic          slotTimeout;
  logic [DW-1:0] slotDelta;
  logic [CW-1:0] slotElapsed;
  logic          takeSlot;

  logic [DW-1:0] curDelta;
  logic          curTimeout;
  logic [CW-1:0] divisor;
  logic [NW-1:0] quot;
  logic [CW-1:0] rem;
  logic [BW-1:0] bitCnt;

  logic [CW:0]   remShift;
  logic          remGe;
  logic [NW-1:0] quotNext;
  logic [QW-1:0] quotWide;
  logic [VW-1:0] satResult;

  // Change has priority over timeout; nothing fires until prev is primed.
  assign changeEv   = primed && (desplazamiento != prev);
  assign timeoutEv  = primed && !changeEv && (cnt == CNT_LAST);
  assign eventNow   = changeEv || timeoutEv;
  assign deltaNow   = desplazamiento - prev;
  assign elapsedNow = cnt + CW'(1);

  // The slot is consumed whenever the divider can start a new job.
  assign takeSlot = slotFull && ((state == IDLE) || (state == DONE));
  assign ocupado  = (state != IDLE);

  // Restoring-division step: remainder always stays below divisor, so CW bits suffice.
  assign remShift  = {rem, quot[NW-1]};
  assign remGe     = (remShift >= {1'b0, divisor});
  assign quotNext  = {quot[NW-2:0], remGe};
  assign quotWide  = QW'(quotNext);
  assign satResult = (quotWide > V_MAX) ? V_MAX[VW-1:0] : quotWide[VW-1:0];

  // Measurement windows: priming, free-running window counter, event pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      primed  <= 1'b0;
      prev    <= '0;
      cnt     <= '0;
      impulso <= 1'b0;
    end else begin
      impulso <= eventNow;
      if (!primed) begin
        primed <= 1'b1;
        prev   <= desplazamiento;
        cnt    <= '0;
      end else if (eventNow) begin
        prev <= desplazamiento;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Pending slot plus the multiply/divide sequencer with registered results.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      slotFull        <= 1'b0;
      slotTimeout     <= 1'b0;
      slotDelta       <= '0;
      slotElapsed     <= '0;
      overrun         <= 1'b0;
      curDelta        <= '0;
      curTimeout      <= 1'b0;
      divisor         <= '0;
      quot            <= '0;
      rem             <= '0;
      bitCnt          <= '0;
      velocidad       <= '0;
      velocidad_valid <= 1'b0;
      detenido        <= 1'b0;
    end else begin
      velocidad_valid <= 1'b0;

      if (eventNow) begin
        slotFull    <= 1'b1;
        slotDelta   <= deltaNow;
        slotElapsed <= elapsedNow;
        slotTimeout <= timeoutEv;
        if (slotFull && !takeSlot) begin
          overrun <= 1'b1;
        end
      end else if (takeSlot) begin
        slotFull <= 1'b0;
      end

      case (state)
        IDLE, DONE: begin
          if (slotFull) begin
            curDelta   <= slotDelta;
            divisor    <= slotElapsed;
            curTimeout <= slotTimeout;
            state      <= MUL;
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          quot   <= NW'(curDelta) * K_N;
          rem    <= '0;
          bitCnt <= '0;
          state  <= DIV;
        end
        DIV: begin
          quot   <= quotNext;
          rem    <= remGe ? CW'(remShift - {1'b0, divisor}) : remShift[CW-1:0];
          bitCnt <= bitCnt + BW'(1);
          if (bitCnt == BW'(NW - 1)) begin
            velocidad       <= satResult;
            detenido        <= curTimeout && (curDelta == '0);
            velocidad_valid <= 1'b1;
            state           <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
